// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register with valid/ready handshake, optional 2-entry skid buffer,
// flush-to-bubble and late-field writeback into the head entry.
module pipe_stage_buf #(
    parameter int                CTRL_W   = 16,
    parameter int                DATA_W   = 128,
    parameter int                LATE_W   = 32,
    parameter logic [CTRL_W-1:0] LATE_CLR = 'h3,
    parameter int                SKID     = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              late_valid,
    input  logic [LATE_W-1:0] late_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [LATE_W-1:0] out_late,
    output logic              out_late_ok,
    output logic [1:0]        occupancy
);

    logic [1:0]        cnt_q, cnt_d;
    logic              rdy_q, rdy_d;
    logic [CTRL_W-1:0] h_ctrl_q, h_ctrl_d, t_ctrl_q, t_ctrl_d;
    logic [DATA_W-1:0] h_data_q, h_data_d, t_data_q, t_data_d;
    logic [LATE_W-1:0] h_late_q, h_late_d, t_late_q, t_late_d;
    logic              h_lok_q, h_lok_d, t_lok_q, t_lok_d;

    logic              head_vld, late_wr, push, pop;
    logic [CTRL_W-1:0] h_ctrl_w;
    logic [LATE_W-1:0] h_late_w;
    logic              h_lok_w;

    assign head_vld = (cnt_q != 2'd0);
    assign late_wr  = late_valid & head_vld;

    // Head fields with the late write applied; doubles as the output bypass.
    assign h_ctrl_w = late_wr ? (h_ctrl_q & ~LATE_CLR) : h_ctrl_q;
    assign h_late_w = late_wr ? late_data : h_late_q;
    assign h_lok_w  = late_wr | h_lok_q;

    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = rdy_q & ~flush;
        end else begin : g_single
            assign in_ready = rdy_q & ~flush & (~head_vld | out_ready);
        end
    endgenerate

    assign push = in_valid & in_ready;
    assign pop  = head_vld & out_ready;

    assign out_valid   = head_vld;
    assign out_ctrl    = head_vld ? h_ctrl_w : '0;
    assign out_data    = head_vld ? h_data_q : '0;
    assign out_late    = head_vld ? h_late_w : '0;
    assign out_late_ok = head_vld & h_lok_w;
    assign occupancy   = cnt_q;

    always_comb begin
        cnt_d    = cnt_q;
        h_ctrl_d = h_ctrl_w;
        h_data_d = h_data_q;
        h_late_d = h_late_w;
        h_lok_d  = h_lok_w;
        t_ctrl_d = t_ctrl_q;
        t_data_d = t_data_q;
        t_late_d = t_late_q;
        t_lok_d  = t_lok_q;

        if (flush) begin
            cnt_d    = 2'd0;
            h_ctrl_d = '0;
            h_data_d = '0;
            h_late_d = '0;
            h_lok_d  = 1'b0;
            t_ctrl_d = '0;
            t_data_d = '0;
            t_late_d = '0;
            t_lok_d  = 1'b0;
        end else begin
            case (cnt_q)
                2'd0: begin
                    if (push) begin
                        cnt_d    = 2'd1;
                        h_ctrl_d = in_ctrl;
                        h_data_d = in_data;
                        h_late_d = '0;
                        h_lok_d  = 1'b0;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        h_ctrl_d = in_ctrl;
                        h_data_d = in_data;
                        h_late_d = '0;
                        h_lok_d  = 1'b0;
                    end else if (push) begin
                        cnt_d    = 2'd2;
                        t_ctrl_d = in_ctrl;
                        t_data_d = in_data;
                        t_late_d = '0;
                        t_lok_d  = 1'b0;
                    end else if (pop) begin
                        cnt_d    = 2'd0;
                        h_ctrl_d = '0;
                        h_data_d = '0;
                        h_late_d = '0;
                        h_lok_d  = 1'b0;
                    end
                end
                default: begin
                    // Full: the tail is promoted untouched by any late write.
                    if (pop) begin
                        cnt_d    = 2'd1;
                        h_ctrl_d = t_ctrl_q;
                        h_data_d = t_data_q;
                        h_late_d = t_late_q;
                        h_lok_d  = t_lok_q;
                        t_ctrl_d = '0;
                        t_data_d = '0;
                        t_late_d = '0;
                        t_lok_d  = 1'b0;
                    end
                end
            endcase
        end

        rdy_d = (SKID != 0) ? (cnt_d != 2'd2) : 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q    <= 2'd0;
            rdy_q    <= 1'b0;
            h_ctrl_q <= '0;
            h_data_q <= '0;
            h_late_q <= '0;
            h_lok_q  <= 1'b0;
            t_ctrl_q <= '0;
            t_data_q <= '0;
            t_late_q <= '0;
            t_lok_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rdy_q    <= rdy_d;
            h_ctrl_q <= h_ctrl_d;
            h_data_q <= h_data_d;
            h_late_q <= h_late_d;
            h_lok_q  <= h_lok_d;
            t_ctrl_q <= t_ctrl_d;
            t_data_q <= t_data_d;
            t_late_q <= t_late_d;
            t_lok_q  <= t_lok_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: scoreboard-checked SKID=1 instance plus directed SKID=0 instance.
module tb_pipe_stage_buf;

    localparam logic [15:0] CLR = 16'h0003;

    typedef struct packed {
        logic [15:0]  c;
        logic [127:0] d;
        logic [31:0]  l;
        logic         ok;
    } ent_t;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         in_valid = 1'b0, in_ready;
    logic [15:0]  in_ctrl = '0;
    logic [127:0] in_data = '0;
    logic         late_valid = 1'b0;
    logic [31:0]  late_data = '0;
    logic         flush = 1'b0;
    logic         out_valid, out_ready = 1'b0;
    logic [15:0]  out_ctrl;
    logic [127:0] out_data;
    logic [31:0]  out_late;
    logic         out_late_ok;
    logic [1:0]   occupancy;

    logic         z_in_valid = 1'b0, z_in_ready;
    logic [15:0]  z_in_ctrl = '0;
    logic [127:0] z_in_data = '0;
    logic         z_late_valid = 1'b0;
    logic [31:0]  z_late_data = '0;
    logic         z_flush = 1'b0;
    logic         z_out_valid, z_out_ready = 1'b0;
    logic [15:0]  z_out_ctrl;
    logic [127:0] z_out_data;
    logic [31:0]  z_out_late;
    logic         z_out_late_ok;
    logic [1:0]   z_occupancy;

    int   n_chk = 0;
    int   n_fail = 0;
    ent_t q[$];
    ent_t mon_e;
    logic exp_rdy = 1'b0;

    always #5 CLK = ~CLK;

    pipe_stage_buf #(.SKID(1)) u_dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .late_valid(late_valid), .late_data(late_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .out_late(out_late), .out_late_ok(out_late_ok),
        .occupancy(occupancy)
    );

    pipe_stage_buf #(.SKID(0)) u_dut0 (
        .CLK(CLK), .RST(RST),
        .in_valid(z_in_valid), .in_ready(z_in_ready), .in_ctrl(z_in_ctrl), .in_data(z_in_data),
        .late_valid(z_late_valid), .late_data(z_late_data), .flush(z_flush),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_ctrl(z_out_ctrl),
        .out_data(z_out_data), .out_late(z_out_late), .out_late_ok(z_out_late_ok),
        .occupancy(z_occupancy)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every negedge compares the head against the model queue.
    always @(negedge CLK) begin
        if (RST) begin
            chk("rst_in_ready", in_ready, 1'b0);
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_occ", occupancy, 2'd0);
            q.delete();
            exp_rdy = 1'b1;
        end else begin
            chk("occ", occupancy, q.size());
            chk("out_valid", out_valid, q.size() != 0);
            chk("in_ready", in_ready, exp_rdy && !flush);
            if (q.size() != 0) begin
                mon_e = q[0];
                if (late_valid) begin
                    mon_e.c  = mon_e.c & ~CLR;
                    mon_e.l  = late_data;
                    mon_e.ok = 1'b1;
                end
                chk("head_ctrl", out_ctrl, mon_e.c);
                chk("head_data", out_data, mon_e.d);
                chk("head_late", out_late, mon_e.l);
                chk("head_late_ok", out_late_ok, mon_e.ok);
                if (out_ready) void'(q.pop_front());
                else q[0] = mon_e;
            end else begin
                chk("bubble_ctrl", out_ctrl, '0);
                chk("bubble_data", out_data, '0);
                chk("bubble_late", {out_late, out_late_ok}, '0);
            end
            if (flush) q.delete();
            else if (in_valid && in_ready) q.push_back('{in_ctrl, in_data, 32'h0, 1'b0});
            exp_rdy = (q.size() < 2);
        end
    end

    task automatic drive(input logic vi, input logic [15:0] c, input logic [127:0] d,
                         input logic lv, input logic [31:0] ld, input logic fl, input logic ordy);
        @(posedge CLK);
        #1;
        in_valid   = vi;
        in_ctrl    = c;
        in_data    = d;
        late_valid = lv;
        late_data  = ld;
        flush      = fl;
        out_ready  = ordy;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 16'h0, 128'h0, 1'b0, 32'h0, 1'b0, ordy);
    endtask

    // Present a beat and hold it until the stage accepts it (bounded wait).
    task automatic push_hold(input logic [15:0] c, input logic [127:0] d, input logic ordy);
        int k;
        k = 0;
        drive(1'b1, c, d, 1'b0, 32'h0, 1'b0, ordy);
        @(negedge CLK);
        while (!in_ready && k < 20) begin
            @(negedge CLK);
            k++;
        end
        if (k >= 20) chk("accept_timeout", 1'b0, 1'b1);
    endtask

    initial begin
        #1;
        chk("z_rst_in_ready", z_in_ready, 1'b0);
        chk("z_rst_occ", z_occupancy, 2'd0);
        repeat (2) @(negedge CLK);
        #1 RST = 1'b0;

        // streaming
        for (int i = 1; i <= 8; i++) drive(1'b1, 16'h0, 128'(i), 1'b0, 32'h0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // backpressure: A, B fill the skid; C waits upstream
        push_hold(16'h0010, 128'hA, 1'b0);
        push_hold(16'h0020, 128'hB, 1'b0);
        drive(1'b1, 16'h0030, 128'hC, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge CLK);
        chk("bp_occ_full", occupancy, 2'd2);
        push_hold(16'h0030, 128'hC, 1'b1);
        repeat (3) idle(1'b1);

        // late write, held then popped
        push_hold(16'h0003, 128'h11, 1'b0);
        drive(1'b0, 16'h0, 128'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        idle(1'b0);
        @(negedge CLK);
        chk("late_held_ctrl", out_ctrl, 16'h0000);
        chk("late_held_val", out_late, 32'hDEADBEEF);
        idle(1'b1);
        idle(1'b1);
        // late write bypassed into a same-cycle pop
        push_hold(16'h0003, 128'h22, 1'b0);
        drive(1'b0, 16'h0, 128'h0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
        idle(1'b1);
        // late write on popped head does not reach the promoted tail
        push_hold(16'h0003, 128'h33, 1'b0);
        push_hold(16'h0003, 128'h44, 1'b0);
        drive(1'b0, 16'h0, 128'h0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b1);
        // late write while empty is ignored
        drive(1'b0, 16'h0, 128'h0, 1'b1, 32'h12345678, 1'b0, 1'b1);
        push_hold(16'h0001, 128'h55, 1'b1);
        idle(1'b1);

        // flush with full stage and a pending upstream beat
        push_hold(16'h0004, 128'h66, 1'b0);
        push_hold(16'h0004, 128'h77, 1'b0);
        drive(1'b1, 16'h0005, 128'h88, 1'b0, 32'h0, 1'b1, 1'b0);
        push_hold(16'h0005, 128'h88, 1'b0);
        idle(1'b1);
        idle(1'b1);
        // flush at occupancy 1 with a same-cycle pop
        push_hold(16'h0006, 128'h99, 1'b0);
        drive(1'b1, 16'h0007, 128'hAA, 1'b0, 32'h0, 1'b1, 1'b1);
        idle(1'b1);

        // random traffic
        for (int i = 0; i < 300; i++)
            drive(1'($urandom_range(0, 1)), 16'($urandom), {$urandom, $urandom, $urandom, $urandom},
                  ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 1)));
        idle(1'b1);
        idle(1'b1);

        // asynchronous reset mid-stream at occupancy 2
        push_hold(16'h0008, 128'hB1, 1'b0);
        push_hold(16'h0008, 128'hB2, 1'b0);
        idle(1'b0);
        #2 RST = 1'b1;
        #1;
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_occ", occupancy, 2'd0);
        chk("arst_data", out_data, '0);
        chk("arst_ctrl", out_ctrl, '0);
        chk("arst_in_ready", in_ready, 1'b0);
        @(negedge CLK);
        #1 RST = 1'b0;
        idle(1'b1);
        #1 chk("arst_in_ready_after", in_ready, 1'b1);
        idle(1'b1);

        // SKID=0 instance
        @(posedge CLK); #1;
        z_in_valid = 1'b1; z_in_data = 128'hF1; z_in_ctrl = 16'h0002; z_out_ready = 1'b0;
        @(negedge CLK);
        chk("z_empty_ready", z_in_ready, 1'b1);
        @(posedge CLK); #1;
        z_in_data = 128'hF2;
        @(negedge CLK);
        chk("z_held_ready", z_in_ready, 1'b0);
        chk("z_held_data", z_out_data, 128'hF1);
        chk("z_held_occ", z_occupancy, 2'd1);
        @(posedge CLK); #1;
        z_out_ready = 1'b1;
        @(negedge CLK);
        chk("z_pass_ready", z_in_ready, 1'b1);
        chk("z_pass_data", z_out_data, 128'hF1);
        @(posedge CLK); #1;
        z_in_valid = 1'b0;
        @(negedge CLK);
        chk("z_new_data", z_out_data, 128'hF2);
        chk("z_new_valid", z_out_valid, 1'b1);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("z_empty_valid", z_out_valid, 1'b0);
        chk("z_empty_data", z_out_data, '0);
        chk("z_empty_occ", z_occupancy, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised pipeline-stage register for the pipelined core. It is the generalised successor of the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control field, a payload field and a late-arriving field (memory return) between stages, using a valid/ready handshake instead of raw ihit/dhit gating.
- Optional 2-entry skid buffer breaks the ready path.
- Supports flush to bubble, and late-field writeback into a held entry with selective control-bit clearing.

Parameters:
- CTRL_W, 16: control bits (e.g. RegWEN, MemtoReg, dREN, dWEN, halt); zeroed in a bubble.
- DATA_W, 128: payload bits (instruction, npc, operands, ALU result).
- LATE_W, 32: late field width (e.g. dmemload).
- LATE_CLR, 16'h0003: CTRL_W-bit mask; ctrl bits set in the mask are cleared when the late field is written (stops re-issue of dREN/dWEN).
- SKID, 1: 1 selects 2-entry skid buffer with registered in_ready; 0 selects single entry with combinational in_ready.

Ports:
- CLK  in  1  clock; all state changes on posedge.
- RST  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_ctrl  in  CTRL_W  upstream control.
- in_data  in  DATA_W  upstream payload.
- late_valid  in  1  late field available this cycle (dhit).
- late_data  in  LATE_W  late field value.
- flush  in  1  kill all held entries.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts.
- out_ctrl  out  CTRL_W  head control (after LATE_CLR).
- out_data  out  DATA_W  head payload.
- out_late  out  LATE_W  head late field (bypassed, see below).
- out_late_ok  out  1  head late field is valid.
- occupancy  out  2  entries held, 0..(SKID?2:1).

Behaviour:
- Entry fields: {ctrl, data, late, late_ok}.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Entries leave only in FIFO order.

Reset (RST=1, async):
- All entries cleared; occupancy=0.
- out_valid=0; out_ctrl, out_data, out_late, out_late_ok all 0.
- in_ready=0 while RST is high; in_ready=1 from the first clock edge after release.

Empty stage:
- out_valid=0, and all out_* fields are driven to 0 (bubble).

Flush (highest priority, synchronous):
- At the next edge all entries are invalidated and occupancy becomes 0.
- in_ready is forced to 0 during the flush cycle, so no push occurs.
- A pop in the same cycle still completes downstream; the downstream stage owns its own flush.

Late write:
- When late_valid=1 and an entry exists, the head entry's late field is set to late_data, late_ok is set to 1, and ctrl is ANDed with ~LATE_CLR at the edge.
- late_valid with the stage empty is ignored.
- Late write never targets the tail entry.
- Bypass: while late_valid=1 and out_valid=1:
  - out_late = late_data
  - out_late_ok = 1
  - out_ctrl = head ctrl & ~LATE_CLR, combinationally.
- Consequence: a pop in the same cycle transfers the late value.
- Late write on a popped head does not carry to the next entry.

SKID=1:
- in_ready is registered and equals (occupancy<2) for the next cycle, accounting for that edge's push, pop and flush.
- Occupancy transitions:
  - 0 + push → 1.
  - 1 + push, no pop → 2.
  - 1 + push + pop → 1; the new beat becomes head.
  - 2 + pop → 1; the tail is promoted to head with its late_ok intact.
  - 2 + push is impossible (in_ready=0).

SKID=0:
- in_ready = ~out_valid | out_ready, combinational.
- The entry register loads on push; it clears on pop without push.

Pushed entries:
- late=0, late_ok=0, with ctrl and data as presented.

Throughput and latency:
- One beat per cycle with out_ready held at 1.
- Latency is 1 cycle from push to out_valid.

Test Plan:
- Reset mid-stream: occupancy=2, assert RST asynchronously between edges → out_valid=0, all outputs 0 and occupancy=0 immediately; in_ready=1 after the first edge following release.
- Streaming: out_ready=1, push data 1..8, one per cycle → out_data 1..8 on consecutive cycles one cycle later; in_ready stays 1; occupancy stays 1.
- Backpressure (SKID=1): out_ready=0, push A then B → occupancy=2, in_ready=0; a third beat C is held upstream. out_ready=1 → A, B, C emerge in order with no loss.
- Late write: head ctrl=16'h0003, late_valid=1, late_data=32'hDEADBEEF, out_ready=0 → next cycle out_ctrl=16'h0000, out_late=DEADBEEF, out_late_ok=1. Repeat with out_ready=1 in the same cycle → the popped beat carries DEADBEEF via bypass.
- Flush with push: occupancy=2, flush=1, in_valid=1 → in_ready=0 that cycle; next cycle occupancy=0 and out_* are 0; the upstream beat is accepted the following cycle.
- SKID=0: out_ready=0 with entry held → in_ready=0. Raise out_ready with in_valid=1 → pop and push on the same edge, and out_data updates to the new beat.
